// File: rtl/app_rx_buf.sv
// Store-and-forward receive buffer: collects payload beats into frames, commits a frame
// after an idle gap, and only then presents its words to the consumer.
//
// state   | meaning
// IDLE    | no frame open, waiting for the first beat
// RECV    | frame open, storing beats and counting idle cycles
// DISCARD | frame dropped, ignoring beats until an idle gap
module app_rx_buf #(
    parameter int DATA_W = 16,
    parameter int KEEP_W = DATA_W / 8,
    parameter int LEN_W  = $clog2(KEEP_W + 1),
    parameter int DEPTH  = 64,
    parameter int GAP_N  = 2
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              valid_i,
    input  logic              cancel_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [LEN_W-1:0]  len_o,
    output logic              last_o,
    output logic              drop_o,
    output logic              ovf_o
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DISC = 2'd2;

    localparam logic [2:0]     GAP_LAST = 3'(GAP_N - 1);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [LEN_W-1:0]  r_mem_len  [DEPTH];
    logic              r_mem_last [DEPTH];

    logic [1:0]     r_state;
    logic [2:0]     r_gap;
    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_cm_ptr;
    logic [PTR_W:0] r_rd_ptr;
    logic           r_drop;
    logic           r_ovf;

    logic [1:0]       w_state_nxt;
    logic [2:0]       w_gap_nxt;
    logic [PTR_W:0]   w_wr_nxt;
    logic [PTR_W:0]   w_cm_nxt;
    logic             w_we;
    logic             w_commit;
    logic             w_drop;
    logic             w_ovf;
    logic             w_full;
    logic             w_pop;
    logic             w_write_req;
    logic [PTR_W-1:0] w_wr_idx;
    logic [PTR_W-1:0] w_last_idx;
    logic [PTR_W-1:0] w_rd_idx;

    // Occupancy counts uncommitted words too, so an open frame can never overrun unread data.
    assign w_full      = (r_wr_ptr - r_rd_ptr) == FULL_CNT;
    assign w_write_req = valid_i && !cancel_i && (len_i != '0);
    assign w_wr_idx    = r_wr_ptr[PTR_W-1:0];
    assign w_last_idx  = w_wr_idx - PTR_W'(1);
    assign w_rd_idx    = r_rd_ptr[PTR_W-1:0];

    assign valid_o = r_rd_ptr != r_cm_ptr;
    assign w_pop   = valid_o && ready_i;
    assign data_o  = r_mem_data[w_rd_idx];
    assign len_o   = r_mem_len[w_rd_idx];
    assign last_o  = r_mem_last[w_rd_idx];
    assign drop_o  = r_drop;
    assign ovf_o   = r_ovf;

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        w_wr_nxt    = r_wr_ptr;
        w_cm_nxt    = r_cm_ptr;
        w_we        = 1'b0;
        w_commit    = 1'b0;
        w_drop      = 1'b0;
        w_ovf       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (valid_i) begin
                    w_gap_nxt = 3'd0;
                    if (cancel_i) begin
                        w_state_nxt = ST_DISC;
                    end else if (w_write_req && w_full) begin
                        w_drop      = 1'b1;
                        w_ovf       = 1'b1;
                        w_wr_nxt    = r_cm_ptr;
                        w_state_nxt = ST_DISC;
                    end else begin
                        w_state_nxt = ST_RECV;
                        if (w_write_req) begin
                            w_we     = 1'b1;
                            w_wr_nxt = r_wr_ptr + 1'b1;
                        end
                    end
                end
            end
            ST_RECV: begin
                if (cancel_i) begin
                    w_drop      = 1'b1;
                    w_wr_nxt    = r_cm_ptr;
                    w_gap_nxt   = 3'd0;
                    w_state_nxt = ST_DISC;
                end else if (valid_i) begin
                    w_gap_nxt = 3'd0;
                    if (w_write_req) begin
                        if (w_full) begin
                            w_drop      = 1'b1;
                            w_ovf       = 1'b1;
                            w_wr_nxt    = r_cm_ptr;
                            w_state_nxt = ST_DISC;
                        end else begin
                            w_we     = 1'b1;
                            w_wr_nxt = r_wr_ptr + 1'b1;
                        end
                    end
                end else if (r_gap == GAP_LAST) begin
                    w_gap_nxt   = 3'd0;
                    w_state_nxt = ST_IDLE;
                    if (r_wr_ptr != r_cm_ptr) begin
                        w_commit = 1'b1;
                        w_cm_nxt = r_wr_ptr;
                    end
                end else begin
                    w_gap_nxt = r_gap + 3'd1;
                end
            end
            ST_DISC: begin
                if (valid_i) begin
                    w_gap_nxt = 3'd0;
                end else if (r_gap == GAP_LAST) begin
                    w_gap_nxt   = 3'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap + 3'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gap_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state  <= ST_IDLE;
            r_gap    <= 3'd0;
            r_wr_ptr <= '0;
            r_cm_ptr <= '0;
            r_rd_ptr <= '0;
            r_drop   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_gap    <= w_gap_nxt;
            r_wr_ptr <= w_wr_nxt;
            r_cm_ptr <= w_cm_nxt;
            r_rd_ptr <= r_rd_ptr + (PTR_W + 1)'(w_pop);
            r_drop   <= w_drop;
            r_ovf    <= w_ovf;
        end
    end

    // Storage is deliberately not reset; only committed entries are ever presented.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem_data[w_wr_idx] <= data_i;
            r_mem_len[w_wr_idx]  <= len_i;
            r_mem_last[w_wr_idx] <= 1'b0;
        end
        if (w_commit) begin
            r_mem_last[w_last_idx] <= 1'b1;
        end
    end

endmodule

// File: doc/app_rx_buf.md
APP_RX_BUF -- requirements
Module: app_rx_buf

Interface
REQ-001 Parameter DATA_W, default 16, payload word width in bits.
REQ-002 Parameter KEEP_W, default DATA_W/8, bytes per word.
REQ-003 Parameter LEN_W, default $clog2(KEEP_W+1), width of the byte-count fields.
REQ-004 Parameter DEPTH, default 64, buffer depth in words; power of 2, at least 4.
REQ-005 Parameter GAP_N, default 2, number of consecutive idle cycles that closes a frame; range 1..7.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 nreset  in  1  synchronous, active-low reset.
REQ-008 valid_i  in  1  payload beat valid (from transport stage app_valid_o).
REQ-009 cancel_i  in  1  abort current frame (from app_cancel_o).
REQ-010 data_i  in  DATA_W  payload word, byte 0 in LSBs.
REQ-011 len_i  in  LEN_W  valid bytes in data_i, 0..KEEP_W.
REQ-012 ready_i  in  1  consumer accepts output word.
REQ-013 valid_o  out  1  output word available.
REQ-014 data_o  out  DATA_W  output word.
REQ-015 len_o  out  LEN_W  valid bytes in data_o.
REQ-016 last_o  out  1  data_o is the final word of its frame.
REQ-017 drop_o  out  1  one-cycle pulse when an open frame is discarded (cancel or overflow).
REQ-018 ovf_o  out  1  one-cycle pulse when the discard cause is overflow.

Function
REQ-019 The block SHALL be store-and-forward: no word of a frame reaches the output before the whole frame is committed.
REQ-020 The block SHALL keep a write pointer, a commit pointer and a read pointer, each PTR_W+1 bits wide (PTR_W=log2 DEPTH), with the MSB used for wrap detection.
REQ-021 States SHALL be IDLE, RECV and DISCARD, plus a gap counter that is cleared on every valid_i=1 cycle.
REQ-022 In IDLE, valid_i=1 with cancel_i=0 SHALL move to RECV and write the beat.
REQ-023 In IDLE, valid_i=1 with cancel_i=1 SHALL move to DISCARD with no write and no drop_o.
REQ-024 A beat with len_i=0 SHALL NOT be written but SHALL keep the frame open.
REQ-025 Each write SHALL store {data_i, len_i, last=0} at the write pointer and increment it.
REQ-026 In RECV, each valid_i=0 cycle SHALL increment the gap counter; when the count reaches GAP_N, the block SHALL commit and return to IDLE.
REQ-027 On commit, the block SHALL set last=1 on the word at write pointer minus 1 and set the commit pointer to the write pointer.
REQ-028 A frame with no stored words SHALL commit nothing.
REQ-029 In RECV, cancel_i=1 SHALL discard the frame: write pointer reset to the commit pointer, drop_o=1, go to DISCARD, and the same-cycle beat not written (cancel wins).
REQ-030 Full SHALL be write pointer minus read pointer equal to DEPTH, evaluated on registered pointers; a same-cycle pop does not free space.
REQ-031 A write attempt while full SHALL discard the frame: write pointer reset to the commit pointer, drop_o=1, ovf_o=1, go to DISCARD.
REQ-032 In DISCARD, all beats SHALL be ignored; after GAP_N consecutive idle cycles the block SHALL return to IDLE without a commit.
REQ-033 valid_o SHALL be 1 while the read pointer differs from the commit pointer.
REQ-034 data_o, len_o and last_o SHALL be read combinationally from the read-pointer entry.
REQ-035 A pop (valid_o=1 and ready_i=1) SHALL increment the read pointer.
REQ-036 Outputs SHALL hold stable while valid_o=1 and ready_i=0.
REQ-037 Latency: valid_o SHALL rise the cycle after the commit edge.
REQ-038 With ready_i=1, one word SHALL be output per cycle.
REQ-039 Commit and pop in the same cycle SHALL both take effect.
REQ-040 Frames SHALL be output in arrival order, and only committed frames are ever output.
REQ-041 A frame longer than DEPTH words SHALL always be dropped with ovf_o.

Reset
REQ-042 nreset=0 at a clock edge SHALL clear all pointers and the gap counter, force IDLE, and drive valid_o=0, drop_o=0, ovf_o=0.
REQ-043 Memory contents SHALL NOT be reset.
REQ-044 A frame in progress at reset SHALL be lost, and reset SHALL NOT pulse drop_o.

Verification (DATA_W=16, DEPTH=8, GAP_N=2)
REQ-045 Basic frame: beats 0xB2A1/2, 0xD4C3/2, 0x00E5/1, then 2 idle cycles, ready_i=1 -> valid_o rises the cycle after commit; three words output in order; last_o=1 only on 0x00E5/1.
REQ-046 Cancel: 3-beat frame with cancel_i on beat 2 -> drop_o one pulse, ovf_o=0, no output; the next 2-beat frame is output intact.
REQ-047 Overflow: 9-beat frame with ready_i=0 -> ovf_o and drop_o pulse on beat 9, valid_o stays 0, and the next frame is accepted.
REQ-048 Short gap: 2 beats, 1 idle cycle, 2 beats, 2 idle cycles -> one 4-word frame with last_o on word 4.
REQ-049 Back-pressure: two 3-word frames, ready_i held 0 for 10 cycles then 1 -> six words in order, stable while stalled, last_o on words 3 and 6.
REQ-050 Reset mid-frame: nreset=0 after beat 2 of a frame -> valid_o=0, no drop_o; the next frame after reset is output correctly.
